// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential restoring IEEE-754 single divider, one quotient bit per clock.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; the default build truncates.
`timescale 1ns/1ps
module fp_div_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  div_by_zero,
    output logic                  invalid
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        NORM,
        DONE
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] a, b;
    logic                  sign;
    logic signed [9:0]     exp_q;
    logic [24:0]           rem;
    logic [23:0]           dvs;
    logic [25:0]           q;
    logic [4:0]            cnt;

    logic        spec_pend;
    logic [31:0] spec_res;
    logic        spec_dbz;
    logic        spec_inv;

    logic zero1, inf1, nan1;
    logic zero2, inf2, nan2;
    logic sgn;
    logic special;
    logic [31:0] spec_val;
    logic spec_dbz_c, spec_inv_c;
    logic signed [9:0] exp_init;

    assign zero1 = (a[30:23] == 8'd0);
    assign inf1  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign nan1  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign zero2 = (b[30:23] == 8'd0);
    assign inf2  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign nan2  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign sgn   = a[31] ^ b[31];

    assign exp_init = $signed({2'b00, a[30:23]})
                    - $signed({2'b00, b[30:23]})
                    + 10'sd127;

    // Priority order matters: NaN cases win over divide-by-zero.
    always_comb begin
        special    = 1'b1;
        spec_val   = 32'd0;
        spec_dbz_c = 1'b0;
        spec_inv_c = 1'b0;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spec_val   = QNAN;
            spec_inv_c = 1'b1;
        end else if (zero2 && !inf1) begin
            spec_val   = {sgn, 8'hFF, 23'd0};
            spec_dbz_c = 1'b1;
        end else if (inf1) begin
            spec_val = {sgn, 8'hFF, 23'd0};
        end else if (zero1 || inf2) begin
            spec_val = {sgn, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    logic        ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_nxt;

    assign ge      = (rem >= {1'b0, dvs});
    assign rem_sub = ge ? (rem - {1'b0, dvs}) : rem;
    assign rem_nxt = rem_sub << 1;

    logic [23:0]       mant;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] e_n, e_f;
    logic [31:0]       norm_res;
`ifdef FP_DIV_ROUND_EN
    logic guard, sticky;
`endif

    always_comb begin
        if (q[25]) begin
            mant = q[25:2];
            e_n  = exp_q;
        end else begin
            mant = q[24:1];
            e_n  = exp_q - 10'sd1;
        end
`ifdef FP_DIV_ROUND_EN
        guard  = q[25] ? q[1] : q[0];
        sticky = (q[25] & q[0]) | (rem != 25'd0);
        mant_r = {1'b0, mant}
               + {24'd0, guard & (sticky | mant[0])};
`else
        mant_r = {1'b0, mant};
`endif
        if (mant_r[24]) begin
            frac = mant_r[23:1];
            e_f  = e_n + 10'sd1;
        end else begin
            frac = mant_r[22:0];
            e_f  = e_n;
        end
        if (e_f >= 10'sd255)
            norm_res = {sign, 8'hFF, 23'd0};
        else if (e_f <= 10'sd0)
            norm_res = {sign, 31'd0};
        else
            norm_res = {sign, e_f[7:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Specials also pass through NORM so they share the output load point.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = PREP;
            PREP: state_nxt = special ? NORM : ITER;
            ITER: if (cnt == 5'd25) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            b           <= '0;
            sign        <= 1'b0;
            exp_q       <= '0;
            rem         <= '0;
            dvs         <= '0;
            q           <= '0;
            cnt         <= '0;
            spec_pend   <= 1'b0;
            spec_res    <= '0;
            spec_dbz    <= 1'b0;
            spec_inv    <= 1'b0;
            out         <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a <= in1;
                        b <= in2;
                    end
                end
                PREP: begin
                    spec_pend <= special;
                    spec_res  <= spec_val;
                    spec_dbz  <= spec_dbz_c;
                    spec_inv  <= spec_inv_c;
                    sign      <= sgn;
                    exp_q     <= exp_init;
                    rem       <= {2'b01, a[22:0]};
                    dvs       <= {1'b1, b[22:0]};
                    q         <= '0;
                    cnt       <= '0;
                end
                ITER: begin
                    rem <= rem_nxt;
                    q   <= {q[24:0], ge};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    out         <= spec_pend ? spec_res : norm_res;
                    div_by_zero <= spec_pend & spec_dbz;
                    invalid     <= spec_pend & spec_inv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: table-driven check of fp_div_seq with a result scoreboard.
// Expected values track FP_DIV_ROUND_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        div_by_zero;
    logic        invalid;

    always #5 clk = ~clk;

    fp_div_seq #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dbz;
        logic        inv;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        dbz;
        logic        inv;
    } exp_t;

`ifdef FP_DIV_ROUND_EN
    localparam logic [31:0] THIRD = 32'h3EAA_AAAB;
    localparam logic [31:0] NEAR1 = 32'h3F80_0001;
`else
    localparam logic [31:0] THIRD = 32'h3EAA_AAAA;
    localparam logic [31:0] NEAR1 = 32'h3F80_0000;
`endif

    exp_t sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int lat);
        int   n = 0;
        exp_t e;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 100);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_lat"}, n, lat);
        e = sb.pop_front();
        chk({name, "_out"}, out, e.q);
        chk({name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        chk({name, "_inv"}, 32'(invalid), 32'(e.inv));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h3F800000, 32'h40400000, THIRD,        1'b0, 1'b0, 28});
        vecs.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 2});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h3F800000, 32'h00400000, 32'h7F800000, 1'b1, 1'b0, 2});
        vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'hC1200000, 32'h40A00000, 32'hC0000000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, NEAR1,        1'b0, 1'b0, 28});
        vecs.push_back('{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 28});
        vecs.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 28});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in1       = 32'd0;
        in2       = 32'd0;
        #12;
        chk("rst_out", out, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_inv", 32'(invalid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1;
        in1      = 32'h40C00000;
        in2      = 32'h40000000;
        @(posedge clk);
        #1;
        chk("rst_no_capture", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            sb.push_back('{vecs[i].q, vecs[i].dbz, vecs[i].inv});
            accept(vecs[i].a, vecs[i].b);
            collect(nm, vecs[i].lat);
            @(posedge clk);
            #1;
            chk({nm, "_idle"}, 32'(in_ready), 32'd1);
        end

        out_ready = 1'b0;
        sb.push_back('{32'h40400000, 1'b0, 1'b0});
        in1      = 32'h40C00000;
        in2      = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in1 = 32'h3F800000;
        in2 = 32'h40000000;
        collect("hold", 28);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("hold_out", out, 32'h40400000);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        sb.push_back('{32'h3F000000, 1'b0, 1'b0});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_ready", 32'(in_ready), 32'd1);
        chk("hs_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("second_taken", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        collect("second", 28);
        @(posedge clk);
        #1;

        accept(32'h40C00000, 32'h40000000);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_idle", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        sb.push_back('{32'h40400000, 1'b0, 1'b0});
        accept(32'h40C00000, 32'h40000000);
        collect("after_rst", 28);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
